// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      FAULT
   } state_e;

   localparam int RETRY_W = 4;

   function automatic int cnt_width(input int pll_rst_cyc, input int lock_timeout_cyc,
                                    input int lock_stable_cyc, input int release_gap_cyc);
      int m;
      m = pll_rst_cyc;
      if (lock_timeout_cyc > m) m = lock_timeout_cyc;
      if (lock_stable_cyc > m) m = lock_stable_cyc;
      if (release_gap_cyc > m) m = release_gap_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; resets to 0.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification supervisor that releases downstream domain
// resets in index order once lock has been stable long enough.
//
// state     | meaning
// PLL_RST   | pll_rst held high for PLL_RST_CYC cycles
// WAIT_LOCK | waiting for synced lock, bounded by LOCK_TIMEOUT_CYC
// STABLE    | counting consecutive locked cycles
// RELEASE   | releasing dom_rst_n bits one per RELEASE_GAP_CYC
// RUN       | all domains out of reset
// FAULT     | retry budget exhausted, held until clr_status
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int NUM_OUTS         = 3,
   parameter int SYNC_STAGES      = 2,
   parameter int PLL_RST_CYC      = 32,
   parameter int LOCK_TIMEOUT_CYC = 1048576,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int RELEASE_GAP_CYC  = 16,
   parameter int MAX_RETRY        = 3
) (
   input  logic                refclk,
   input  logic                rst_n,
   input  logic                pll_locked,
   input  logic                clr_status,
   output logic                pll_rst,
   output logic [NUM_OUTS-1:0] dom_rst_n,
   output logic                all_ready,
   output logic                lock_lost,
   output logic [RETRY_W-1:0]  retry_cnt,
   output logic                fault
);

   localparam int CNT_W = cnt_width(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC,
                                    RELEASE_GAP_CYC);
   localparam logic [CNT_W-1:0] PLL_RST_LD = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   // The WAIT_LOCK cycle that saw lock counts as the first stable cycle.
   localparam logic [CNT_W-1:0] STABLE_LD  =
      CNT_W'((LOCK_STABLE_CYC > 1) ? LOCK_STABLE_CYC - 2 : 0);
   localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(RELEASE_GAP_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                pll_rst_q, pll_rst_d;
   logic [NUM_OUTS-1:0] dom_q, dom_d;
   logic                all_ready_q, all_ready_d;
   logic                lock_lost_q, lock_lost_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic                fault_q, fault_d;
   logic                locked_s;
   logic                cnt_zero;
   logic [RETRY_W-1:0]  retry_base, retry_inc;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
      retry_base  = clr_status ? '0 : retry_q;
      retry_inc   = (retry_base == '1) ? retry_base : retry_base + RETRY_W'(1);
      retry_d     = retry_base;
      lock_lost_d = clr_status ? 1'b0 : lock_lost_q;

      case (state_q)
         PLL_RST: begin
            if (cnt_zero) begin
               state_d = WAIT_LOCK;
               cnt_d   = TIMEOUT_LD;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               if (LOCK_STABLE_CYC <= 1) begin
                  state_d = RELEASE;
                  cnt_d   = GAP_LD;
               end else begin
                  state_d = STABLE;
                  cnt_d   = STABLE_LD;
               end
            end else if (cnt_zero) begin
               retry_d = retry_inc;
               if (MAX_RETRY != 0 && retry_inc == RETRY_LIM) begin
                  state_d = FAULT;
               end else begin
                  state_d = PLL_RST;
                  cnt_d   = PLL_RST_LD;
               end
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = TIMEOUT_LD;
            end else if (cnt_zero) begin
               state_d = RELEASE;
               cnt_d   = GAP_LD;
            end
         end
         RELEASE, RUN: begin
            if (!locked_s) begin
               state_d     = PLL_RST;
               cnt_d       = PLL_RST_LD;
               lock_lost_d = 1'b1;
            end else if (state_q == RELEASE) begin
               if (dom_q[NUM_OUTS-1]) state_d = RUN;
               else if (cnt_zero)     cnt_d   = GAP_LD;
            end
         end
         FAULT: begin
            if (clr_status) begin
               state_d = PLL_RST;
               cnt_d   = PLL_RST_LD;
            end
         end
         default: begin
            state_d = PLL_RST;
            cnt_d   = PLL_RST_LD;
         end
      endcase

      pll_rst_d   = (state_d == PLL_RST) || (state_d == FAULT);
      fault_d     = (state_d == FAULT);
      all_ready_d = (state_d == RUN);
      case (state_d)
         RELEASE: dom_d = (state_q == RELEASE && !cnt_zero) ? dom_q
                                                           : (dom_q << 1) | NUM_OUTS'(1);
         RUN:     dom_d = '1;
         default: dom_d = '0;
      endcase
   end

   // Reset is treated as an entry into PLL_RST, so the counter starts loaded.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PLL_RST;
         cnt_q       <= PLL_RST_LD;
         pll_rst_q   <= 1'b1;
         dom_q       <= '0;
         all_ready_q <= 1'b0;
         lock_lost_q <= 1'b0;
         retry_q     <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pll_rst_q   <= pll_rst_d;
         dom_q       <= dom_d;
         all_ready_q <= all_ready_d;
         lock_lost_q <= lock_lost_d;
         retry_q     <= retry_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign dom_rst_n = dom_q;
   assign all_ready = all_ready_q;
   assign lock_lost = lock_lost_q;
   assign retry_cnt = retry_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer against a timeline-based reference model.
module tb_pll_reset_sequencer;

   localparam int NUM_OUTS         = 3;
   localparam int SYNC_STAGES      = 2;
   localparam int PLL_RST_CYC      = 4;
   localparam int LOCK_TIMEOUT_CYC = 64;
   localparam int LOCK_STABLE_CYC  = 8;
   localparam int RELEASE_GAP_CYC  = 4;
   localparam int MAX_RETRY        = 2;

   localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;

   logic                refclk = 1'b0;
   logic                rst_n = 1'b0;
   logic                pll_locked = 1'b0;
   logic                clr_status = 1'b0;
   logic                pll_rst;
   logic [NUM_OUTS-1:0] dom_rst_n;
   logic                all_ready;
   logic                lock_lost;
   logic [3:0]          retry_cnt;
   logic                fault;

   int n_pass = 0;
   int n_total = 0;

   int m_ph, m_age, m_retry;
   bit m_lost;
   bit m_hist[SYNC_STAGES];

   always #5 refclk = ~refclk;

   pll_reset_sequencer #(
      .NUM_OUTS(NUM_OUTS), .SYNC_STAGES(SYNC_STAGES), .PLL_RST_CYC(PLL_RST_CYC),
      .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC), .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
      .RELEASE_GAP_CYC(RELEASE_GAP_CYC), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .clr_status(clr_status),
      .pll_rst(pll_rst), .dom_rst_n(dom_rst_n), .all_ready(all_ready),
      .lock_lost(lock_lost), .retry_cnt(retry_cnt), .fault(fault)
   );

   task automatic model_reset();
      m_ph = P_RST; m_age = 1; m_retry = 0; m_lost = 0;
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 0;
   endtask

   // Phase timeline: m_age is the 1-based cycle index within the current phase.
   task automatic model_edge(input bit lk, input bit clr);
      bit ls;
      int nph;
      int base;
      ls = m_hist[SYNC_STAGES-1];
      for (int i = SYNC_STAGES-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = lk;
      base = clr ? 0 : m_retry;
      m_retry = base;
      if (clr) m_lost = 0;
      nph = m_ph;
      case (m_ph)
         P_RST:  if (m_age == PLL_RST_CYC) nph = P_WAIT;
         P_WAIT: begin
            if (ls) nph = P_STAB;
            else if (m_age == LOCK_TIMEOUT_CYC) begin
               m_retry = (base < 15) ? base + 1 : 15;
               nph = (MAX_RETRY != 0 && m_retry == MAX_RETRY) ? P_FAULT : P_RST;
            end
         end
         P_STAB: begin
            if (!ls) nph = P_WAIT;
            else if (m_age + 1 == LOCK_STABLE_CYC) nph = P_REL;
         end
         P_REL: begin
            if (!ls) begin nph = P_RST; m_lost = 1; end
            else if (m_age == (NUM_OUTS-1)*RELEASE_GAP_CYC + 1) nph = P_RUN;
         end
         P_RUN:   if (!ls) begin nph = P_RST; m_lost = 1; end
         P_FAULT: if (clr) nph = P_RST;
         default: nph = P_RST;
      endcase
      m_age = (nph == m_ph) ? m_age + 1 : 1;
      m_ph = nph;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
   endtask

   task automatic check_all(input string tag);
      int n;
      logic [31:0] exp_dom;
      exp_dom = 0;
      if (m_ph == P_REL) begin
         n = 1 + (m_age - 1) / RELEASE_GAP_CYC;
         if (n > NUM_OUTS) n = NUM_OUTS;
         exp_dom = (32'd1 << n) - 32'd1;
      end else if (m_ph == P_RUN) begin
         exp_dom = (32'd1 << NUM_OUTS) - 32'd1;
      end
      chk({tag, ".pll_rst"},   32'(pll_rst),   32'(m_ph == P_RST || m_ph == P_FAULT));
      chk({tag, ".dom_rst_n"}, 32'(dom_rst_n), exp_dom);
      chk({tag, ".all_ready"}, 32'(all_ready), 32'(m_ph == P_RUN));
      chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(m_lost));
      chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(m_retry));
      chk({tag, ".fault"},     32'(fault),     32'(m_ph == P_FAULT));
   endtask

   task automatic cyc(input string tag, input bit lk, input bit clr, input bit rel = 0);
      @(negedge refclk);
      if (rel) rst_n = 1'b1;
      pll_locked = lk;
      clr_status = clr;
      @(posedge refclk);
      if (rst_n) model_edge(lk, clr);
      #1 check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #12 check_all("reset");

      // Normal bring-up: rst_n released for cycle T0, lock raised at T10.
      cyc("bringup", 0, 0, 1);
      for (int t = 1; t < 10; t++) cyc("bringup", 0, 0);
      for (int t = 10; t < 36; t++) cyc("bringup", 1, 0);
      chk("run_reached", 32'(all_ready), 32'd1);
      for (int t = 0; t < 8; t++) cyc("run_clr", 1, ($urandom_range(0, 3) == 0));

      // Loss of lock in RUN, relock after a random delay, twice.
      for (int k = 0; k < 2; k++) begin
         int down;
         down = $urandom_range(1, 8);
         for (int t = 0; t < down; t++) cyc("run_loss", 0, 0);
         for (int t = 0; t < 45; t++) cyc("relock", 1, 0);
      end

      // Lock glitch in STABLE, using the canonical timeline.
      async_reset("async_rst_a");
      cyc("glitch", 0, 0);
      cyc("glitch", 0, 0, 1);
      for (int t = 1; t < 10; t++) cyc("glitch", 0, 0);
      for (int t = 10; t < 15; t++) cyc("glitch", 1, 0);
      cyc("glitch", 0, 0);
      for (int t = 16; t < 50; t++) cyc("glitch", 1, 0);

      // Timeouts until FAULT, then clr_status recovery.
      for (int t = 0; t < 300 && m_ph != P_FAULT; t++) cyc("timeout", 0, 0);
      chk("fault_reached", 32'(fault), 32'd1);
      for (int t = 0; t < 6; t++) cyc("fault_hold", $urandom_range(0, 1), 0);
      cyc("fault_clr", 0, 1);
      // clr_status on the exact timeout edge leaves retry_cnt at 1.
      for (int t = 0; t < 75; t++)
         cyc("timeout_clr", 0, (m_ph == P_WAIT && m_age == LOCK_TIMEOUT_CYC));
      chk("retry_after_clr", 32'(retry_cnt), 32'd1);
      for (int t = 0; t < 45; t++) cyc("recover", 1, 0);

      // clr_status on the same edge the loss is acted on.
      cyc("clr_loss", 0, 0);
      cyc("clr_loss", 0, 0);
      cyc("clr_loss", 0, 1);
      chk("lock_lost_set_wins", 32'(lock_lost), 32'd1);
      for (int t = 0; t < 45; t++) cyc("recover2", 1, 0);

      // Asynchronous reset part-way through RELEASE.
      cyc("pre_rel", 0, 0);
      for (int t = 0; t < 100 && m_ph != P_REL; t++) cyc("to_release", 1, 0);
      chk("in_release", 32'(dom_rst_n[0]), 32'd1);
      cyc("in_release", 1, 0);
      async_reset("async_rst_b");
      cyc("held_rst", 1, 0);
      cyc("restart", 1, 0, 1);
      for (int t = 0; t < 40; t++) cyc("restart", 1, 0);

      // Random soak.
      for (int t = 0; t < 600; t++)
         cyc("soak", ($urandom_range(0, 24) != 0), ($urandom_range(0, 19) == 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
